// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined RISC-V core. Owns the PC, runs a
// request/acknowledge handshake to instruction memory and drives the IF/ID
// pipeline register. A one-entry holding buffer catches an instruction that
// returns while ID is stalled, so nothing fetched is lost or duplicated.
//
// Parameters
//   PC_RESET        first fetch address after reset (word aligned)
//   NOP_INST        instruction shown on inst_o while valid_o = 0
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous active-high reset (also aborts a pending fetch)
//   stall_i         hold PC and IF/ID (load-use hazard)
//   flush_i         branch taken in ID: squash IF/ID, redirect to target
//   branch_target_i redirect address, bits [1:0] ignored
//   imem_req_o      fetch request
//   imem_addr_o     fetch address, stable until acknowledged
//   imem_ack_i      one-cycle acknowledge, imem_data_i valid with it
//   imem_data_i     fetched instruction word
//   valid_o         IF/ID holds a real instruction
//   pc_o            PC of the IF/ID instruction
//   inst_o          IF/ID instruction, NOP_INST when not valid
//   opcode_o        inst_o[6:0], straight to the control unit
//
// State     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | just out of reset, no request yet
// ST_REQ    | request to pc_q outstanding
// ST_FULL   | holding buffer occupied while ID stalls, no request
// ST_DRAIN  | request flushed but not yet acked, data will be dropped
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [6:0]  opcode_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic [31:0] target_aligned;
  logic [31:0] pc_inc;
  logic        target_lsb_unused;

  assign target_aligned    = {branch_target_i[31:2], 2'b00};
  assign target_lsb_unused = ^branch_target_i[1:0];
  assign pc_inc            = pc_q + 32'd4;

  // A flushed request keeps presenting its original address until memory
  // answers; pc_q already points at the branch target by then.
  assign imem_req_o  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem_addr_o = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

  assign valid_o  = if_valid_q;
  assign pc_o     = if_pc_q;
  assign inst_o   = if_valid_q ? if_inst_q : NOP_INST;
  assign opcode_o = inst_o[6:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= PC_RESET;
      drain_addr_q <= PC_RESET;
      buf_pc_q     <= 32'h0;
      buf_inst_q   <= 32'h0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'h0;
      if_inst_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_pc_q     <= buf_pc_d;
      buf_inst_q   <= buf_inst_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
    end
  end

  // imem_ack_i is only looked at in ST_REQ / ST_DRAIN, the two states that
  // drive a request; an ack anywhere else is a protocol error and ignored.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_pc_d     = buf_pc_q;
    buf_inst_d   = buf_inst_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (flush_i) begin
          if_valid_d = 1'b0;
          pc_d       = target_aligned;
        end
      end

      ST_REQ: begin
        if (flush_i) begin
          if_valid_d = 1'b0;
          pc_d       = target_aligned;
          if (!imem_ack_i) begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_ack_i) begin
          pc_d = pc_inc;
          if (stall_i) begin
            buf_pc_d   = pc_q;
            buf_inst_d = imem_data_i;
            state_d    = ST_FULL;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_inst_d  = imem_data_i;
          end
        end else if (!stall_i) begin
          if_valid_d = 1'b0;
        end
      end

      ST_FULL: begin
        if (flush_i) begin
          // Buffered instruction is on the wrong path; leaving FULL drops it.
          if_valid_d = 1'b0;
          pc_d       = target_aligned;
          state_d    = ST_REQ;
        end else if (!stall_i) begin
          if_valid_d = 1'b1;
          if_pc_d    = buf_pc_q;
          if_inst_d  = buf_inst_q;
          state_d    = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (flush_i) begin
          if_valid_d = 1'b0;
          pc_d       = target_aligned;
        end
        if (imem_ack_i) begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives fetch_stage with directed scenarios and then randomized stall, flush,
// reset and memory latency. A transaction-level model (next PC, a queue for
// the stall buffer, a flag for a stale outstanding request) predicts every
// output each cycle; directed phases also check literal values.
// A second instance with PC_RESET = FFFF_FFF8 shares the stimulus and is used
// for the PC wrap scenario.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W_RESET = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        ack = 1'b0;
  logic [31:0] data = 32'h0;

  logic        req, valid;
  logic [31:0] addr, pc, inst;
  logic [6:0]  opc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_inst;
  logic [6:0]  w_opc;

  fetch_stage dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .branch_target_i(tgt), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_data_i(data), .valid_o(valid), .pc_o(pc),
    .inst_o(inst), .opcode_o(opc)
  );

  fetch_stage #(.PC_RESET(W_RESET)) dut_w (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .branch_target_i(tgt), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ack_i(ack), .imem_data_i(data), .valid_o(w_valid), .pc_o(w_pc),
    .inst_o(w_inst), .opcode_o(w_opc)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int          mem_cnt = 0;
  int          mem_lat = 0;
  int          fixed_lat = 0;
  bit          rand_lat = 1'b0;
  bit          spur_en = 1'b0;
  logic [31:0] key = 32'h0;

  always @(posedge clk) begin
    if (rst_i || !req) begin
      mem_cnt = 0;
      mem_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    end else if (ack) begin
      mem_cnt = 0;
      mem_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    end else begin
      mem_cnt++;
    end
    #1;
    if (req && mem_cnt >= mem_lat) begin
      ack  = 1'b1;
      data = addr ^ key;
    end else begin
      ack  = spur_en && !req && ($urandom_range(0, 7) == 0);
      data = $urandom;
    end
  end

  // ---------------- behavioural reference ----------------
  bit          started = 1'b0;
  bit          stale = 1'b0;
  logic [31:0] stale_addr = 32'h0;
  logic [31:0] m_pc = 32'h0;
  logic [63:0] hold_q[$];
  bit          m_v = 1'b0;
  logic [31:0] m_ifpc = 32'h0;
  logic [31:0] m_ifinst = 32'h0;

  function automatic bit m_req();
    return started && (stale || hold_q.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return stale ? stale_addr : m_pc;
  endfunction

  always @(posedge clk) begin : model
    bit          rq, acc;
    logic [63:0] e;
    rq  = m_req();
    acc = rq && ack;
    if (rst_i) begin
      started  = 1'b0;
      stale    = 1'b0;
      m_pc     = 32'h0;
      hold_q.delete();
      m_v      = 1'b0;
      m_ifpc   = 32'h0;
      m_ifinst = 32'h0;
    end else if (!started) begin
      started = 1'b1;
      if (flush_i) m_pc = {tgt[31:2], 2'b00};
    end else if (flush_i) begin
      m_v = 1'b0;
      hold_q.delete();
      if (rq && !stale && !acc) begin
        stale      = 1'b1;
        stale_addr = m_pc;
      end else if (acc) begin
        stale = 1'b0;
      end
      m_pc = {tgt[31:2], 2'b00};
    end else if (stale) begin
      if (acc) stale = 1'b0;
    end else if (hold_q.size() != 0) begin
      if (!stall_i) begin
        e        = hold_q.pop_front();
        m_v      = 1'b1;
        m_ifpc   = e[63:32];
        m_ifinst = e[31:0];
      end
    end else if (acc) begin
      if (stall_i) hold_q.push_back({m_pc, data});
      else begin
        m_v      = 1'b1;
        m_ifpc   = m_pc;
        m_ifinst = data;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall_i) begin
      m_v = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] exp_inst;
    if (chk_en) begin
      exp_inst = m_v ? m_ifinst : NOP;
      chk("req", 32'(req), 32'(m_req()));
      chk("addr", addr, m_addr());
      chk("valid", 32'(valid), 32'(m_v));
      chk("pc", pc, m_ifpc);
      chk("inst", inst, exp_inst);
      chk("opcode", 32'(opc), 32'(exp_inst[6:0]));
      chk("w_req", 32'(w_req), 32'(m_req()));
      chk("w_valid", 32'(w_valid), 32'(m_v));
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_opcode", 32'(opc), 32'h13);
    chk("rst_w_addr", w_addr, W_RESET);

    // zero-wait streaming, inst = addr
    rst_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("a_valid", 32'(valid), 32'(k >= 2));
      if (k >= 2) begin
        chk("a_pc", pc, 32'(4 * (k - 2)));
        chk("a_inst", inst, 32'(4 * (k - 2)));
      end
    end

    // stall for two cycles while ack of PC 12 lands
    do_reset();
    repeat (4) step();
    chk("b_pc8", pc, 32'h8);
    stall_i = 1'b1;
    step();
    chk("b_frozen_pc", pc, 32'h8);
    chk("b_frozen_valid", 32'(valid), 32'h1);
    chk("b_full_req", 32'(req), 32'h0);
    step();
    chk("b_frozen_pc2", pc, 32'h8);
    chk("b_full_req2", 32'(req), 32'h0);
    stall_i = 1'b0;
    step();
    chk("b_pc12", pc, 32'hC);
    chk("b_addr16", addr, 32'h10);
    step();
    chk("b_pc16", pc, 32'h10);

    // 3-cycle ack latency, then flush while 0x10 is outstanding
    fixed_lat = 2;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("c_addr", addr, 32'(4 * ((k - 1) / 3)));
      chk("c_valid", 32'(valid), 32'(k >= 4 && (k - 4) % 3 == 0));
      if (k >= 4 && (k - 4) % 3 == 0) chk("c_pc", pc, 32'(4 * ((k - 4) / 3)));
    end
    flush_i = 1'b1;
    tgt     = 32'h40;
    step();
    flush_i = 1'b0;
    chk("d_valid0", 32'(valid), 32'h0);
    chk("d_addr_hold", addr, 32'h10);
    chk("d_req", 32'(req), 32'h1);
    step();
    chk("d_addr_hold2", addr, 32'h10);
    chk("d_valid1", 32'(valid), 32'h0);
    step();
    chk("d_addr_tgt", addr, 32'h40);
    chk("d_valid2", 32'(valid), 32'h0);
    step();
    chk("d_valid3", 32'(valid), 32'h0);
    step();
    chk("d_valid4", 32'(valid), 32'h0);
    step();
    chk("d_tgt_valid", 32'(valid), 32'h1);
    chk("d_tgt_pc", pc, 32'h40);
    chk("d_tgt_inst", inst, 32'h40);

    // flush + stall while FULL, unaligned target
    fixed_lat = 0;
    do_reset();
    repeat (3) step();
    chk("e_pc4", pc, 32'h4);
    stall_i = 1'b1;
    step();
    chk("e_full_req", 32'(req), 32'h0);
    chk("e_full_pc", pc, 32'h4);
    flush_i = 1'b1;
    tgt     = 32'h43;
    step();
    chk("e_valid0", 32'(valid), 32'h0);
    chk("e_addr40", addr, 32'h40);
    flush_i = 1'b0;
    stall_i = 1'b0;
    step();
    chk("e_pc40", pc, 32'h40);
    chk("e_valid", 32'(valid), 32'h1);
    step();
    chk("e_pc44", pc, 32'h44);

    // PC wrap on the second instance, then reset mid-stream
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("f_w_valid", 32'(w_valid), 32'(k >= 2));
      if (k >= 2) chk("f_w_pc", w_pc, W_RESET + 32'(4 * (k - 2)));
    end
    rst_i = 1'b1;
    step();
    chk("f_rst_req", 32'(req), 32'h0);
    chk("f_rst_valid", 32'(valid), 32'h0);
    chk("f_rst_pc", pc, 32'h0);
    chk("f_rst_inst", inst, NOP);
    chk("f_rst_opcode", 32'(opc), 32'h13);
    chk("f_rst_addr", addr, 32'h0);
    chk("f_rst_w_addr", w_addr, W_RESET);
    chk("f_rst_w_pc", w_pc, 32'h0);
    chk("f_rst_w_inst", w_inst, NOP);
    chk("f_rst_w_opcode", 32'(w_opc), 32'h13);
    chk("f_rst_w_req", 32'(w_req), 32'h0);
    rst_i = 1'b0;

    // randomized traffic
    rand_lat = 1'b1;
    spur_en  = 1'b1;
    key      = $urandom;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 12) == 0);
      tgt     = $urandom;
      rst_i   = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
